// File: rtl/p_to_s_converter_if.sv
// rtl/p_to_s_converter_if.sv - frame-in / chunk-out handshake bundle for p_to_s_converter.
interface p_to_s_converter_if #(
  parameter int SERIAL_LENGTH   = 2,
  parameter int PARALLEL_LENGTH = 4,
  parameter int DATA_WIDTH      = 32
);
  logic                                        ien;
  logic [0:PARALLEL_LENGTH-1][DATA_WIDTH-1:0]  idata;
  logic                                        iready;
  logic                                        oen;
  logic                                        oready;
  logic [0:SERIAL_LENGTH-1][DATA_WIDTH-1:0]    odata;
  logic                                        finished;

  // Converter side: takes frames in, drives chunks out.
  modport slave (
    input  ien, idata, oready,
    output iready, oen, odata, finished
  );

  // Environment side: frame producer plus chunk consumer.
  modport master (
    output ien, idata, oready,
    input  iready, oen, odata, finished
  );
endinterface

// File: rtl/p_to_s_converter.sv
// rtl/p_to_s_converter.sv - parallel frame to serial chunk converter; optional P_TO_S_OVERRUN_EN adds a sticky overrun flag.
module p_to_s_converter #(
  parameter int SERIAL_LENGTH   = 2,
  parameter int PARALLEL_LENGTH = 4,
  parameter int DATA_WIDTH      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fct,
`ifdef P_TO_S_OVERRUN_EN
  output logic              overrun,
`endif
  p_to_s_converter_if.slave bus
);

  localparam int NB_CHUNKS = PARALLEL_LENGTH / SERIAL_LENGTH;
  localparam int CW        = (NB_CHUNKS > 1) ? $clog2(NB_CHUNKS) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NB_CHUNKS - 1);

  generate
    if ((PARALLEL_LENGTH % SERIAL_LENGTH) != 0 || PARALLEL_LENGTH < SERIAL_LENGTH) begin : g_bad_len
      $error("PARALLEL_LENGTH must be a positive multiple of SERIAL_LENGTH");
    end
  endgenerate

  typedef enum logic {IDLE, SEND} state_t;

  state_t                                     state_q;
  logic [CW-1:0]                              chunk_q;
  logic [CW-1:0]                              chunk_d;
  logic [0:PARALLEL_LENGTH-1][DATA_WIDTH-1:0] buf_q;
  logic [0:SERIAL_LENGTH-1][DATA_WIDTH-1:0]   odata_q;
  logic [0:SERIAL_LENGTH-1][DATA_WIDTH-1:0]   first_chunk_d;
  logic [0:SERIAL_LENGTH-1][DATA_WIDTH-1:0]   next_chunk_d;
  logic                                       oen_q;
  logic                                       finished_q;
  logic                                       iready;
`ifdef P_TO_S_OVERRUN_EN
  logic                                       overrun_q;
`endif

  assign iready  = fct && (state_q == IDLE);
  assign chunk_d = chunk_q + CW'(1);

  // Chunk 0 comes straight from the incoming frame so oen rises one cycle after ien.
  always_comb begin
    first_chunk_d = '0;
    next_chunk_d  = '0;
    for (int j = 0; j < SERIAL_LENGTH; j++) begin
      first_chunk_d[j] = bus.idata[j];
      next_chunk_d[j]  = buf_q[chunk_d * SERIAL_LENGTH + j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      chunk_q    <= '0;
      buf_q      <= '0;
      odata_q    <= '0;
      oen_q      <= 1'b0;
      finished_q <= 1'b0;
`ifdef P_TO_S_OVERRUN_EN
      overrun_q  <= 1'b0;
`endif
    end else if (!fct) begin
      // Disabled block discards any in-flight frame and ignores new ones.
      state_q    <= IDLE;
      chunk_q    <= '0;
      oen_q      <= 1'b0;
      finished_q <= 1'b0;
`ifdef P_TO_S_OVERRUN_EN
      overrun_q  <= 1'b0;
`endif
    end else begin
`ifdef P_TO_S_OVERRUN_EN
      if (bus.ien && !iready) begin
        overrun_q <= 1'b1;
      end
`endif
      case (state_q)
        IDLE: begin
          if (bus.ien) begin
            buf_q      <= bus.idata;
            odata_q    <= first_chunk_d;
            oen_q      <= 1'b1;
            chunk_q    <= '0;
            finished_q <= (NB_CHUNKS == 1);
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (oen_q && bus.oready) begin
            if (chunk_q == LAST_CHUNK) begin
              oen_q      <= 1'b0;
              finished_q <= 1'b0;
              chunk_q    <= '0;
              state_q    <= IDLE;
            end else begin
              chunk_q    <= chunk_d;
              odata_q    <= next_chunk_d;
              finished_q <= (chunk_d == LAST_CHUNK);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.iready   = iready;
  assign bus.oen      = oen_q;
  assign bus.odata    = odata_q;
  assign bus.finished = finished_q;
`ifdef P_TO_S_OVERRUN_EN
  assign overrun      = overrun_q;
`endif

endmodule
